// File: rtl/bp_be_issue_buffer_pkg.sv
// bp_be_pkg: shared types for the backend issue buffer.
//   bp_be_issue_state_e : issue-buffer control state (run / roll / resume).
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_issue_run    = 2'd0,
    e_issue_roll   = 2'd1,
    e_issue_resume = 2'd2
  } bp_be_issue_state_e;

endpackage

// File: rtl/bp_be_issue_buffer_if.sv
// bp_be_issue_buffer_if: handshake bundle between the FE queue FIFO, the
// issue buffer and dispatch/commit logic.
//   master modport : the issue buffer itself (drives yumi, issue, FIFO controls)
//   slave modport  : the surrounding environment (FIFO head, dispatch, commit)
interface bp_be_issue_buffer_if #(
  parameter int fe_queue_width_p    = 128,
  parameter int fe_queue_fifo_els_p = 8,
  parameter int reg_addr_width_p    = 5
);
  localparam int inflight_width_lp = $clog2(fe_queue_fifo_els_p + 1);

  logic [fe_queue_width_p-1:0]  fe_queue_i;
  logic                         fe_queue_v_i;
  logic                         fe_queue_yumi_o;
  logic [reg_addr_width_p-1:0]  rs1_addr_i;
  logic                         rs1_v_i;
  logic [reg_addr_width_p-1:0]  rs2_addr_i;
  logic                         rs2_v_i;
  logic [fe_queue_width_p-1:0]  issue_pkt_o;
  logic                         issue_v_o;
  logic                         issue_ready_i;
  logic [reg_addr_width_p-1:0]  rs1_addr_o;
  logic [reg_addr_width_p-1:0]  rs2_addr_o;
  logic                         commit_v_i;
  logic                         flush_v_i;
  logic                         redirect_v_i;
  logic                         deq_v_o;
  logic                         roll_v_o;
  logic                         clr_v_o;
  logic [inflight_width_lp-1:0] inflight_o;
  logic [31:0]                  stall_cnt_o;

  modport master (
    input  fe_queue_i, fe_queue_v_i, rs1_addr_i, rs1_v_i, rs2_addr_i, rs2_v_i,
           issue_ready_i, commit_v_i, flush_v_i, redirect_v_i,
    output fe_queue_yumi_o, issue_pkt_o, issue_v_o, rs1_addr_o, rs2_addr_o,
           deq_v_o, roll_v_o, clr_v_o, inflight_o, stall_cnt_o
  );

  modport slave (
    output fe_queue_i, fe_queue_v_i, rs1_addr_i, rs1_v_i, rs2_addr_i, rs2_v_i,
           issue_ready_i, commit_v_i, flush_v_i, redirect_v_i,
    input  fe_queue_yumi_o, issue_pkt_o, issue_v_o, rs1_addr_o, rs2_addr_o,
           deq_v_o, roll_v_o, clr_v_o, inflight_o, stall_cnt_o
  );

endinterface

// File: rtl/bp_be_issue_buffer_inflight_counter.sv
// bp_be_inflight_counter: up/down counter of issued-but-uncommitted entries,
// with asynchronous active-low reset and synchronous clear.
//   clk_i, reset_n_i : clock, async active-low reset
//   clear_i          : return to init_val_p next cycle (has priority)
//   up_i / down_i    : step amounts (callers keep the count in [0, max_val_p])
//   count_o          : registered count
module bp_be_inflight_counter #(
  parameter int max_val_p  = 8,
  parameter int init_val_p = 0,
  parameter int max_step_p = 1,
  localparam int width_lp  = $clog2(max_val_p + 1),
  localparam int step_w_lp = $clog2(max_step_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clear_i,
  input  logic [step_w_lp-1:0] up_i,
  input  logic [step_w_lp-1:0] down_i,
  output logic [width_lp-1:0]  count_o
);

  logic [width_lp-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) count_d = width_lp'(init_val_p);
    else         count_d = count_q + width_lp'(up_i) - width_lp'(down_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= width_lp'(init_val_p);
    else            count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_be_issue_buffer.sv
// bp_be_issue_buffer: pops FE queue entries into a single issue register with
// registered rs1/rs2 addresses, tracks in-flight (issued, uncommitted) entries
// and drives the FE queue FIFO's deq/roll/clr controls.
//   clk_i, reset_n_i : clock, async active-low reset
//   io (master)      : FIFO head + prefetched rs addresses in, yumi out;
//                      issue packet/valid out, ready in; commit/flush/redirect
//                      in; deq/roll/clr, inflight count, stall count out.
// Optional: define BP_BE_ISSUE_STALL_CNT_EN for a saturating 32-bit stall
// counter on stall_cnt_o; otherwise stall_cnt_o is tied to 0.
module bp_be_issue_buffer
  import bp_be_pkg::*;
#(
  parameter int fe_queue_width_p    = 128,
  parameter int fe_queue_fifo_els_p = 8,
  parameter int reg_addr_width_p    = 5
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bp_be_issue_buffer_if.master   io
);

  localparam int inflight_width_lp = $clog2(fe_queue_fifo_els_p + 1);

  bp_be_issue_state_e state_q, state_d;

  logic [inflight_width_lp-1:0] inflight_q;
  logic [fe_queue_width_p-1:0]  issue_pkt_q;
  logic [reg_addr_width_p-1:0]  rs1_addr_q, rs2_addr_q;
  logic                         issue_v_q;

  logic full, yumi, deq;

  assign full = (inflight_q == inflight_width_lp'(fe_queue_fifo_els_p));

  // Combinational outputs are gated by reset so everything reads 0 while
  // reset is held, not just the registered outputs.
  always_comb begin
    state_d = state_q;
    yumi    = 1'b0;
    unique case (state_q)
      e_issue_run: begin
        yumi = io.fe_queue_v_i & (~issue_v_q | io.issue_ready_i) & ~full
             & ~io.flush_v_i & ~io.redirect_v_i;
      end
      e_issue_roll:   state_d = e_issue_resume;
      e_issue_resume: state_d = e_issue_run;
      default:        state_d = e_issue_run;
    endcase
    if (io.flush_v_i) state_d = e_issue_roll;
    yumi = yumi & reset_n_i;
  end

  assign deq = reset_n_i & io.commit_v_i & (inflight_q != '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_issue_run;
    else            state_q <= state_d;
  end

  // Flush zeroes the count; a commit in the flush cycle still reaches the
  // FIFO through deq_v_o, so nothing is lost by dropping it here.
  bp_be_inflight_counter #(
    .max_val_p  (fe_queue_fifo_els_p),
    .init_val_p (0),
    .max_step_p (1)
  ) inflight_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (io.flush_v_i),
    .up_i      (yumi),
    .down_i    (deq),
    .count_o   (inflight_q)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      issue_v_q   <= 1'b0;
      issue_pkt_q <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
    end else if (io.flush_v_i) begin
      issue_v_q <= 1'b0;
    end else if (yumi) begin
      issue_v_q   <= 1'b1;
      issue_pkt_q <= io.fe_queue_i;
      rs1_addr_q  <= io.rs1_addr_i;
      rs2_addr_q  <= io.rs2_addr_i;
    end else if (io.issue_ready_i) begin
      issue_v_q <= 1'b0;
    end
  end

`ifdef BP_BE_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        stall_inc;

  assign stall_inc = (issue_v_q & ~io.issue_ready_i) | (io.fe_queue_v_i & full);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                        stall_cnt_q <= '0;
    else if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign io.stall_cnt_o = stall_cnt_q;
`else
  assign io.stall_cnt_o = '0;
`endif

  assign io.fe_queue_yumi_o = yumi;
  assign io.deq_v_o         = deq;
  assign io.roll_v_o        = reset_n_i & io.flush_v_i;
  assign io.clr_v_o         = reset_n_i & io.redirect_v_i;
  assign io.issue_pkt_o     = issue_pkt_q;
  assign io.issue_v_o       = issue_v_q;
  assign io.rs1_addr_o      = rs1_addr_q;
  assign io.rs2_addr_o      = rs2_addr_q;
  assign io.inflight_o      = inflight_q;

  a_rs_valid_on_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi |-> (io.rs1_v_i && io.rs2_v_i));

  a_commit_nonempty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    io.commit_v_i |-> (inflight_q != '0));

endmodule

// File: tb/tb_bp_be_issue_buffer.sv
module tb_bp_be_issue_buffer;
  localparam int W   = 128;
  localparam int ELS = 8;
  localparam int RA  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_issue_buffer_if #(
    .fe_queue_width_p    (W),
    .fe_queue_fifo_els_p (ELS),
    .reg_addr_width_p    (RA)
  ) io ();

  bp_be_issue_buffer #(
    .fe_queue_width_p    (W),
    .fe_queue_fifo_els_p (ELS),
    .reg_addr_width_p    (RA)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (io)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: entries in flight, what sits in the issue slot, and how
  // many cycles of post-flush blackout remain.
  int          m_infl;
  bit          m_v;
  logic [W-1:0]  m_pkt;
  logic [RA-1:0] m_rs1, m_rs2;
  int          m_block;
  longint      m_stall;

  function automatic bit e_yumi();
    return rst_n && io.fe_queue_v_i && (!m_v || io.issue_ready_i) && (m_infl < ELS)
        && !io.flush_v_i && !io.redirect_v_i && (m_block == 0);
  endfunction

  function automatic bit e_deq();
    return rst_n && io.commit_v_i && (m_infl > 0);
  endfunction

  function automatic logic [31:0] e_stall();
`ifdef BP_BE_ISSUE_STALL_CNT_EN
    return 32'(m_stall);
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_infl = 0; m_v = 0; m_pkt = '0; m_rs1 = '0; m_rs2 = '0; m_block = 0; m_stall = 0;
    end else begin
      bit y, d;
      y = e_yumi();
      d = e_deq();
      if ((m_v && !io.issue_ready_i) || (io.fe_queue_v_i && m_infl == ELS))
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
      if (io.flush_v_i) begin
        m_infl  = 0;
        m_v     = 0;
        m_block = 2;
      end else begin
        m_infl = m_infl + int'(y) - int'(d);
        if (m_block > 0) m_block--;
        if (y) begin
          m_v = 1; m_pkt = io.fe_queue_i; m_rs1 = io.rs1_addr_i; m_rs2 = io.rs2_addr_i;
        end else if (io.issue_ready_i) begin
          m_v = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("yumi",     io.fe_queue_yumi_o, e_yumi());
    chk("deq",      io.deq_v_o,  e_deq());
    chk("roll",     io.roll_v_o, rst_n & io.flush_v_i);
    chk("clr",      io.clr_v_o,  rst_n & io.redirect_v_i);
    chk("issue_v",  io.issue_v_o, m_v);
    chk("inflight", io.inflight_o, m_infl);
    chk("stall",    io.stall_cnt_o, e_stall());
    if (m_v) begin
      chk("pkt", io.issue_pkt_o, m_pkt);
      chk("rs1", io.rs1_addr_o,  m_rs1);
      chk("rs2", io.rs2_addr_o,  m_rs2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_yumi"},  io.fe_queue_yumi_o, 0);
    chk({tag, "_deq"},   io.deq_v_o, 0);
    chk({tag, "_roll"},  io.roll_v_o, 0);
    chk({tag, "_clr"},   io.clr_v_o, 0);
    chk({tag, "_iv"},    io.issue_v_o, 0);
    chk({tag, "_pkt"},   io.issue_pkt_o, 0);
    chk({tag, "_rs1"},   io.rs1_addr_o, 0);
    chk({tag, "_infl"},  io.inflight_o, 0);
    chk({tag, "_stall"}, io.stall_cnt_o, 0);
  endtask

  task automatic idle_inputs();
    io.fe_queue_i = '0; io.fe_queue_v_i = 0;
    io.rs1_addr_i = '0; io.rs1_v_i = 1; io.rs2_addr_i = '0; io.rs2_v_i = 1;
    io.issue_ready_i = 1; io.commit_v_i = 0; io.flush_v_i = 0; io.redirect_v_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    // Reset holds every output low even with all controls active.
    #2;
    io.fe_queue_v_i = 1; io.commit_v_i = 1; io.flush_v_i = 1; io.redirect_v_i = 1;
    #1;
    chk_all_zero("reset");
    idle_inputs();
    tick();
    rst_n = 1;

    // First issue, 1-cycle latency.
    io.fe_queue_v_i = 1; io.fe_queue_i = 128'hA5; io.rs1_addr_i = 3; io.rs2_addr_i = 7;
    #1;
    chk("t1_yumi", io.fe_queue_yumi_o, 1);
    tick();
    io.issue_ready_i = 0; io.fe_queue_i = 128'h11; io.rs1_addr_i = 9; io.rs2_addr_i = 10;
    #1;
    chk("t1_iv",   io.issue_v_o, 1);
    chk("t1_pkt",  io.issue_pkt_o, 128'hA5);
    chk("t1_rs1",  io.rs1_addr_o, 3);
    chk("t1_rs2",  io.rs2_addr_o, 7);
    chk("t1_infl", io.inflight_o, 1);

    // Back-pressure for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      chk("t2_yumi", io.fe_queue_yumi_o, 0);
      chk("t2_pkt",  io.issue_pkt_o, 128'hA5);
      tick();
    end
`ifdef BP_BE_ISSUE_STALL_CNT_EN
    chk("t2_stall", io.stall_cnt_o, 4);
`else
    chk("t2_stall", io.stall_cnt_o, 0);
`endif

    // Fill to 8 in flight.
    io.issue_ready_i = 1;
    for (int i = 0; i < 7; i++) begin
      io.fe_queue_i = 128'h100 + 128'(i); io.rs1_addr_i = 5'(i); io.rs2_addr_i = 5'(31 - i);
      tick();
    end
    #1;
    chk("t3_infl8", io.inflight_o, 8);
    chk("t3_pkt",   io.issue_pkt_o, 128'h106);
    chk("t3_rs1",   io.rs1_addr_o, 6);
    chk("t3_rs2",   io.rs2_addr_o, 25);
    chk("t3_full_yumi", io.fe_queue_yumi_o, 0);
    io.commit_v_i = 1;
    #1;
    chk("t3_deq", io.deq_v_o, 1);
    tick();
    io.commit_v_i = 0;
    #1;
    chk("t3_infl7", io.inflight_o, 7);
    chk("t3_yumi_resume", io.fe_queue_yumi_o, 1);
    io.fe_queue_v_i = 0; io.commit_v_i = 1;
    tick();
    tick();
    io.commit_v_i = 0;
    #1;
    chk("t4_infl5", io.inflight_o, 5);

    // Flush with simultaneous commit.
    io.flush_v_i = 1; io.commit_v_i = 1;
    #1;
    chk("t4_roll", io.roll_v_o, 1);
    chk("t4_deq",  io.deq_v_o, 1);
    tick();
    io.flush_v_i = 0; io.commit_v_i = 0;
    io.fe_queue_v_i = 1; io.fe_queue_i = 128'h200; io.rs1_addr_i = 1; io.rs2_addr_i = 2;
    #1;
    chk("t4_iv",    io.issue_v_o, 0);
    chk("t4_infl0", io.inflight_o, 0);
    chk("t4_roll_yumi", io.fe_queue_yumi_o, 0);
    tick();
    chk("t4_resume_yumi", io.fe_queue_yumi_o, 0);
    tick();
    chk("t4_run_yumi", io.fe_queue_yumi_o, 1);

    // Redirect at 3 in flight.
    tick(); tick(); tick();
    chk("t5_infl3", io.inflight_o, 3);
    io.redirect_v_i = 1;
    #1;
    chk("t5_clr",  io.clr_v_o, 1);
    chk("t5_yumi", io.fe_queue_yumi_o, 0);
    tick();
    io.redirect_v_i = 0; io.fe_queue_v_i = 0;
    #1;
    chk("t5_clr_off", io.clr_v_o, 0);
    chk("t5_infl3b",  io.inflight_o, 3);

    // Reset while the issue slot is full.
    io.fe_queue_v_i = 1; io.issue_ready_i = 0; io.fe_queue_i = 128'h300;
    tick();
    chk("t6_iv", io.issue_v_o, 1);
    io.commit_v_i = 1; io.redirect_v_i = 1;
    #1;
    rst_n = 0;
    #1;
    chk_all_zero("rst_run");
    idle_inputs();
    #1;
    rst_n = 1;
    tick();

    // Reset while in ROLL.
    io.fe_queue_v_i = 1; io.fe_queue_i = 128'h400;
    tick();
    io.flush_v_i = 1;
    tick();
    io.flush_v_i = 0; io.commit_v_i = 1; io.redirect_v_i = 1;
    #1;
    rst_n = 0;
    #1;
    chk_all_zero("rst_roll");
    io.commit_v_i = 0; io.redirect_v_i = 0;
    #1;
    rst_n = 1;
    #1;
    chk("t7_run_yumi", io.fe_queue_yumi_o, 1);
    tick();
    chk("t7_iv",  io.issue_v_o, 1);
    chk("t7_pkt", io.issue_pkt_o, 128'h400);
    io.fe_queue_v_i = 0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_be_issue_buffer.md
Name: bp_be_issue_buffer

Overview:
- Backend stage directly downstream of the rollable FE queue FIFO.
- Pops FE queue entries into a single issue register and presents them to the dispatch/scheduler with prefetched rs1/rs2 addresses.
- Counts issued-but-uncommitted entries and generates the FIFO's deq (commit), roll (replay from checkpoint) and clr (drop unread) controls.

Parameters:
fe_queue_width_p, 128, width of one FE queue entry
fe_queue_fifo_els_p, 8, FE queue depth; also the maximum number of in-flight entries
reg_addr_width_p, 5, architectural register address width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
fe_queue_i  in  fe_queue_width_p  FIFO head entry
fe_queue_v_i  in  1  FIFO head valid
fe_queue_yumi_o  out  1  pop FIFO head this cycle
rs1_addr_i  in  reg_addr_width_p  prefetched rs1 address from FIFO
rs1_v_i  in  1  rs1_addr_i valid
rs2_addr_i  in  reg_addr_width_p  prefetched rs2 address from FIFO
rs2_v_i  in  1  rs2_addr_i valid
issue_pkt_o  out  fe_queue_width_p  issue register contents
issue_v_o  out  1  issue register valid
issue_ready_i  in  1  dispatch accepts issue_pkt_o
rs1_addr_o  out  reg_addr_width_p  registered rs1 address for issue_pkt_o
rs2_addr_o  out  reg_addr_width_p  registered rs2 address for issue_pkt_o
commit_v_i  in  1  oldest in-flight entry retired
flush_v_i  in  1  squash uncommitted work; replay from checkpoint
redirect_v_i  in  1  FE redirect; discard unread FIFO entries
deq_v_o  out  1  to FIFO deq_v_i
roll_v_o  out  1  to FIFO roll_v_i
clr_v_o  out  1  to FIFO clr_v_i
inflight_o  out  clog2(fe_queue_fifo_els_p+1)  in-flight count
stall_cnt_o  out  32  stall-cycle counter (optional feature)

Behaviour:
- Reset (async, reset_n_i=0):
  - All outputs 0; state=RUN; inflight=0; issue register invalid.
  - Reset mid-operation drops all state immediately.
- States: RUN, ROLL, RESUME.
- RUN:
  - fe_queue_yumi_o = fe_queue_v_i & (~issue_v_o | issue_ready_i) & (inflight < fe_queue_fifo_els_p) & ~flush_v_i & ~redirect_v_i.
  - On yumi, next cycle: issue_pkt_o <= fe_queue_i; issue_v_o <= 1; rs1_addr_o/rs2_addr_o <= rs1_addr_i/rs2_addr_i. Latency is 1 cycle.
  - rs*_v_i low during yumi is a protocol error (assertion).
  - issue_ready_i with issue_v_o and no yumi: issue_v_o <= 0.
  - Issue register holds contents stable while issue_v_o & ~issue_ready_i.
- Inflight counter:
  - +1 on yumi; -1 on deq_v_o; simultaneous yumi and deq_v_o leaves it unchanged.
  - deq_v_o = commit_v_i & (inflight != 0). Combinational, same cycle.
  - commit_v_i at inflight==0 is ignored and flagged by assertion.
  - Never exceeds fe_queue_fifo_els_p; saturation blocks yumi.
- flush_v_i (any state, highest priority):
  - roll_v_o = 1 the same cycle.
  - deq_v_o still honoured the same cycle; the FIFO adds it into its checkpoint.
  - Next cycle: inflight=0, issue_v_o=0, state=ROLL.
- ROLL: yumi blocked for one cycle; next state RESUME.
- RESUME: yumi blocked for one cycle so the FIFO's prefetched rs addresses settle; next state RUN.
- redirect_v_i in RUN:
  - clr_v_o = 1 the same cycle; yumi blocked that cycle.
  - inflight and issue register unaffected.
  - redirect_v_i together with flush_v_i: both roll_v_o and clr_v_o assert; flush state handling applies.
- inflight_o is the registered counter.

Optional Feature:
- Macro BP_BE_ISSUE_STALL_CNT_EN.
- Defined: stall_cnt_o is a 32-bit counter.
  - Increments each cycle issue_v_o & ~issue_ready_i, or fe_queue_v_i blocked by a full inflight count.
  - Saturates at 2^32-1; cleared by reset.
- Undefined: stall_cnt_o tied to 0; no counter logic.

Decomposition:
- bp_be_pkg: enum bp_be_issue_state_e {e_issue_run, e_issue_roll, e_issue_resume}.
- Inflight counter is the natural sub-module: reuse bsg_counter_up_down (max_val_p=fe_queue_fifo_els_p, init_val_p=0, max_step_p=1) behind a thin async-reset wrapper, bp_be_inflight_counter.

Test Plan:
- Reset, then fe_queue_v_i=1 with entry 0xA5, rs1=3, rs2=7: cycle 0 yumi=1; cycle 1 issue_v_o=1, issue_pkt_o=0xA5, rs1_addr_o=3, rs2_addr_o=7, inflight_o=1.
- issue_ready_i=0 for 4 cycles with fe_queue_v_i=1: yumi=0 and issue_pkt_o stable; with the macro on, stall_cnt_o=4.
- Issue 8 entries with no commit: inflight_o=8, yumi=0 on the 9th; one commit_v_i -> deq_v_o=1, inflight_o=7, yumi resumes next cycle.
- inflight=5 with flush_v_i and commit_v_i in the same cycle: roll_v_o=1, deq_v_o=1; next cycles issue_v_o=0, inflight_o=0, yumi=0 for 2 cycles, then yumi=1.
- redirect_v_i at inflight=3: clr_v_o=1 for 1 cycle, yumi=0 that cycle, inflight_o stays 3.
- Assert reset_n_i=0 while issue_v_o=1 and in ROLL: all outputs 0 immediately (asynchronous); after release, state=RUN.
